// File: rtl/maint_pkg.sv
// Shared types and defaults for the maintenance scheduler.
//   maint_state_t      - scheduler FSM state encoding
//   TREFI_CYC_DEF      - default refresh interval in cycles (7.8 us at 100 MHz)
//   SCRUB_INTERVAL_DEF - default cycles between scrub opportunities
//   debt_w()           - width needed to hold a refresh debt of 0..max_postpone
package maint_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REF,
    S_SCRUB
  } maint_state_t;

  localparam int unsigned TREFI_CYC_DEF      = 780;
  localparam int unsigned SCRUB_INTERVAL_DEF = 4096;

  function automatic int unsigned debt_w(int unsigned max_postpone);
    return $clog2(max_postpone + 1);
  endfunction

endpackage

// File: rtl/maint_interval_timer.sv
// Free-running interval timer: counts 0..PERIOD-1 while en is high, holds while low.
//   clk  - system clock
//   rst  - synchronous active-high reset (count back to 0)
//   en   - count enable
//   tick - high for the single cycle the counter sits at PERIOD-1 with en high
module maint_interval_timer #(
  parameter int unsigned PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    tick    = en && (count_q == CntW'(PERIOD - 1));
    count_d = count_q;
    if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/maint_scheduler.sv
// Maintenance request scheduler: tracks refresh debt against a tREFI timer, allows
// bounded postponement under host traffic, and walks a scrub address range.
// At most one of refresh_req / scrub_req is raised at a time (level req, 1-cycle ack).
//   clk, rst        - clock, synchronous active-high reset
//   host_busy       - host command pending; defers non-urgent maintenance
//   scrub_en        - enables scrub timer and scrub requests
//   refresh_req/ack - refresh handshake
//   refresh_urgent  - debt >= MAX_POSTPONE-1
//   refresh_debt    - outstanding refreshes
//   refresh_overrun - sticky: tick arrived with debt already saturated
//   scrub_req/ack   - scrub handshake; scrub_addr is the current/next scrub address
//   scrub_wrap      - 1-cycle pulse when scrub_addr reloads SCRUB_BASE
module maint_scheduler
  import maint_pkg::*;
#(
  parameter int unsigned       TREFI_CYC      = TREFI_CYC_DEF,
  parameter int unsigned       MAX_POSTPONE   = 8,
  parameter int unsigned       SCRUB_INTERVAL = SCRUB_INTERVAL_DEF,
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] SCRUB_BASE     = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] SCRUB_LIMIT    = ADDR_W'(32'h0010_0000),
  parameter int unsigned       SCRUB_STEP     = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              host_busy,
  input  logic                              scrub_en,
  output logic                              refresh_req,
  input  logic                              refresh_ack,
  output logic                              refresh_urgent,
  output logic [debt_w(MAX_POSTPONE)-1:0]   refresh_debt,
  output logic                              refresh_overrun,
  output logic                              scrub_req,
  output logic [ADDR_W-1:0]                 scrub_addr,
  input  logic                              scrub_ack,
  output logic                              scrub_wrap
);

  localparam int unsigned      DebtW   = debt_w(MAX_POSTPONE);
  localparam logic [DebtW-1:0] DebtMax = DebtW'(MAX_POSTPONE);
  localparam logic [DebtW-1:0] DebtUrg = DebtW'(MAX_POSTPONE - 1);

  logic ref_tick, scrub_tick;

  maint_interval_timer #(
    .PERIOD (TREFI_CYC)
  ) u_ref_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (ref_tick)
  );

  maint_interval_timer #(
    .PERIOD (SCRUB_INTERVAL)
  ) u_scrub_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (scrub_en),
    .tick (scrub_tick)
  );

  maint_state_t      state_q, state_d;
  logic [DebtW-1:0]  debt_q, debt_d;
  logic              urgent_q;
  logic              overrun_q, overrun_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   addr_nxt;
  logic              wrap_q, wrap_d;
  logic              refresh_req_q, scrub_req_q;
  logic              ref_ack_ok, scrub_ack_ok;

  always_comb begin
    // Acks only count while the matching request is actually raised.
    ref_ack_ok   = refresh_ack && refresh_req_q;
    scrub_ack_ok = scrub_ack && scrub_req_q;

    debt_d    = debt_q;
    overrun_d = overrun_q;
    if (ref_tick && !ref_ack_ok) begin
      if (debt_q == DebtMax) begin
        overrun_d = 1'b1;
      end else begin
        debt_d = debt_q + 1'b1;
      end
    end else if (ref_ack_ok && !ref_tick && (debt_q != '0)) begin
      debt_d = debt_q - 1'b1;
    end

    // A tick landing on the ack cycle is a fresh opportunity, so it wins over the clear.
    pending_d = pending_q;
    if (scrub_ack_ok) pending_d = 1'b0;
    if (scrub_tick)   pending_d = 1'b1;
    if (!scrub_en)    pending_d = 1'b0;

    // Extra bit so a step past the top of the address space is still seen as >= limit.
    addr_nxt = {1'b0, addr_q} + (ADDR_W + 1)'(SCRUB_STEP);
    addr_d   = addr_q;
    wrap_d   = 1'b0;
    if (scrub_ack_ok) begin
      if (addr_nxt >= {1'b0, SCRUB_LIMIT}) begin
        addr_d = SCRUB_BASE;
        wrap_d = 1'b1;
      end else begin
        addr_d = addr_nxt[ADDR_W-1:0];
      end
    end

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if ((debt_q != '0) && (!host_busy || urgent_q)) begin
          state_d = S_REF;
        end else if (pending_q && scrub_en && !host_busy && !urgent_q) begin
          state_d = S_SCRUB;
        end
      end
      S_REF:   if (ref_ack_ok)   state_d = S_IDLE;
      S_SCRUB: if (scrub_ack_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      debt_q        <= '0;
      urgent_q      <= 1'b0;
      overrun_q     <= 1'b0;
      pending_q     <= 1'b0;
      addr_q        <= SCRUB_BASE;
      wrap_q        <= 1'b0;
      refresh_req_q <= 1'b0;
      scrub_req_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      debt_q        <= debt_d;
      urgent_q      <= (debt_d >= DebtUrg);
      overrun_q     <= overrun_d;
      pending_q     <= pending_d;
      addr_q        <= addr_d;
      wrap_q        <= wrap_d;
      refresh_req_q <= (state_d == S_REF);
      scrub_req_q   <= (state_d == S_SCRUB);
    end
  end

  assign refresh_req     = refresh_req_q;
  assign refresh_urgent  = urgent_q;
  assign refresh_debt    = debt_q;
  assign refresh_overrun = overrun_q;
  assign scrub_req       = scrub_req_q;
  assign scrub_addr      = addr_q;
  assign scrub_wrap      = wrap_q;

endmodule

// File: tb/tb_maint_scheduler.sv
// Directed bench for maint_scheduler with small timing parameters
// (TREFI 16, MAX_POSTPONE 4, SCRUB_INTERVAL 40, range 0x1000..0x1100 step 64).
// Cycle n means the sample taken 1 ns after the n-th rising edge following the reset edge.
module tb_maint_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_busy;
  logic        scrub_en;
  logic        refresh_req;
  logic        refresh_ack;
  logic        refresh_urgent;
  logic [2:0]  refresh_debt;
  logic        refresh_overrun;
  logic        scrub_req;
  logic [31:0] scrub_addr;
  logic        scrub_ack;
  logic        scrub_wrap;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  maint_scheduler #(
    .TREFI_CYC      (16),
    .MAX_POSTPONE   (4),
    .SCRUB_INTERVAL (40),
    .ADDR_W         (32),
    .SCRUB_BASE     (32'h0000_1000),
    .SCRUB_LIMIT    (32'h0000_1100),
    .SCRUB_STEP     (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host_busy       (host_busy),
    .scrub_en        (scrub_en),
    .refresh_req     (refresh_req),
    .refresh_ack     (refresh_ack),
    .refresh_urgent  (refresh_urgent),
    .refresh_debt    (refresh_debt),
    .refresh_overrun (refresh_overrun),
    .scrub_req       (scrub_req),
    .scrub_addr      (scrub_addr),
    .scrub_ack       (scrub_ack),
    .scrub_wrap      (scrub_wrap)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_reset(input logic busy, input logic sen);
    rst         = 1'b1;
    host_busy   = busy;
    scrub_en    = sen;
    refresh_ack = 1'b0;
    scrub_ack   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    n_checks++;
    if ({refresh_req, refresh_urgent, refresh_overrun, scrub_req, scrub_wrap} !== 5'b0) begin
      $display("FAIL reset_flags: got %b want 00000",
               {refresh_req, refresh_urgent, refresh_overrun, scrub_req, scrub_wrap});
    end else n_pass++;
    n_checks++;
    if (refresh_debt !== 3'd0) $display("FAIL reset_debt: got %0d want 0", refresh_debt);
    else n_pass++;
    n_checks++;
    if (scrub_addr !== 32'h1000) $display("FAIL reset_addr: got %h want 00001000", scrub_addr);
    else n_pass++;
  endtask

  task automatic test_idle_refresh();
    do_reset(1'b0, 1'b0);
    goto(16);
    n_checks++;
    if (refresh_debt !== 3'd1 || refresh_req !== 1'b0) begin
      $display("FAIL idle_ref_c16: got debt %0d req %b want debt 1 req 0", refresh_debt,
               refresh_req);
    end else n_pass++;
    goto(17);
    n_checks++;
    if (refresh_req !== 1'b1) $display("FAIL idle_ref_req_c17: got %b want 1", refresh_req);
    else n_pass++;
    goto(20);
    n_checks++;
    if (refresh_req !== 1'b1) $display("FAIL idle_ref_hold_c20: got %b want 1", refresh_req);
    else n_pass++;
    refresh_ack = 1'b1;
    step(1);
    refresh_ack = 1'b0;
    n_checks++;
    if (refresh_req !== 1'b0 || refresh_debt !== 3'd0) begin
      $display("FAIL idle_ref_ack_c21: got req %b debt %0d want req 0 debt 0", refresh_req,
               refresh_debt);
    end else n_pass++;
  endtask

  task automatic test_postpone();
    do_reset(1'b1, 1'b0);
    goto(20);
    // Stray acks with no request raised must be ignored.
    refresh_ack = 1'b1;
    scrub_ack   = 1'b1;
    step(1);
    refresh_ack = 1'b0;
    scrub_ack   = 1'b0;
    n_checks++;
    if (refresh_debt !== 3'd1 || scrub_addr !== 32'h1000) begin
      $display("FAIL stray_ack: got debt %0d addr %h want debt 1 addr 00001000", refresh_debt,
               scrub_addr);
    end else n_pass++;
    goto(47);
    n_checks++;
    if (refresh_debt !== 3'd2 || refresh_req !== 1'b0 || refresh_urgent !== 1'b0) begin
      $display("FAIL postpone_c47: got debt %0d req %b urg %b want 2 0 0", refresh_debt,
               refresh_req, refresh_urgent);
    end else n_pass++;
    goto(48);
    n_checks++;
    if (refresh_debt !== 3'd3 || refresh_urgent !== 1'b1 || refresh_req !== 1'b0) begin
      $display("FAIL urgent_c48: got debt %0d urg %b req %b want 3 1 0", refresh_debt,
               refresh_urgent, refresh_req);
    end else n_pass++;
    goto(49);
    n_checks++;
    if (refresh_req !== 1'b1) $display("FAIL urgent_req_c49: got %b want 1", refresh_req);
    else n_pass++;
    goto(64);
    n_checks++;
    if (refresh_debt !== 3'd4 || refresh_overrun !== 1'b0) begin
      $display("FAIL debt4_c64: got debt %0d ovr %b want 4 0", refresh_debt, refresh_overrun);
    end else n_pass++;
    goto(79);
    n_checks++;
    if (refresh_overrun !== 1'b0) $display("FAIL ovr_early_c79: got %b want 0", refresh_overrun);
    else n_pass++;
    goto(80);
    n_checks++;
    if (refresh_overrun !== 1'b1 || refresh_debt !== 3'd4) begin
      $display("FAIL overrun_c80: got ovr %b debt %0d want 1 4", refresh_overrun, refresh_debt);
    end else n_pass++;
    goto(100);
    n_checks++;
    if (refresh_overrun !== 1'b1 || refresh_req !== 1'b1) begin
      $display("FAIL overrun_sticky_c100: got ovr %b req %b want 1 1", refresh_overrun,
               refresh_req);
    end else n_pass++;
    // Reset while the refresh request is raised.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if ({refresh_req, refresh_overrun, refresh_urgent} !== 3'b000 || refresh_debt !== 3'd0) begin
      $display("FAIL rst_mid_ref: got req %b ovr %b urg %b debt %0d want 0 0 0 0", refresh_req,
               refresh_overrun, refresh_urgent, refresh_debt);
    end else n_pass++;
  endtask

  task automatic test_collision();
    do_reset(1'b0, 1'b0);
    goto(31);
    n_checks++;
    if (refresh_req !== 1'b1 || refresh_debt !== 3'd1) begin
      $display("FAIL coll_pre_c31: got req %b debt %0d want 1 1", refresh_req, refresh_debt);
    end else n_pass++;
    refresh_ack = 1'b1;  // sampled on the same edge as the second tick
    step(1);
    refresh_ack = 1'b0;
    n_checks++;
    if (refresh_debt !== 3'd1 || refresh_req !== 1'b0) begin
      $display("FAIL coll_c32: got debt %0d req %b want 1 0", refresh_debt, refresh_req);
    end else n_pass++;
    step(1);
    n_checks++;
    if (refresh_req !== 1'b1) $display("FAIL coll_rereq_c33: got %b want 1", refresh_req);
    else n_pass++;
    refresh_ack = 1'b1;
    step(1);
    refresh_ack = 1'b0;
    n_checks++;
    if (refresh_debt !== 3'd0 || refresh_req !== 1'b0) begin
      $display("FAIL coll_done_c34: got debt %0d req %b want 0 0", refresh_debt, refresh_req);
    end else n_pass++;
  endtask

  task automatic test_scrub_walk();
    logic [31:0] exp_addr [6];
    int nscrub = 0;
    int wraps  = 0;
    exp_addr = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 32'h1000, 32'h1040};
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 400 && nscrub < 6; i++) begin
      step(1);
      if (scrub_wrap === 1'b1) begin
        wraps++;
        n_checks++;
        if (scrub_addr !== 32'h1000) $display("FAIL wrap_addr: got %h want 00001000", scrub_addr);
        else n_pass++;
      end
      if (scrub_req === 1'b1) begin
        if (nscrub == 0) begin
          n_checks++;
          if (cyc != 41) $display("FAIL first_scrub_cycle: got %0d want 41", cyc);
          else n_pass++;
        end
        n_checks++;
        if (scrub_addr !== exp_addr[nscrub]) begin
          $display("FAIL scrub_addr_%0d: got %h want %h", nscrub, scrub_addr, exp_addr[nscrub]);
        end else n_pass++;
        nscrub++;
      end
      refresh_ack = refresh_req;
      // Leave the sixth request unacked for the reset check below.
      scrub_ack = scrub_req && (nscrub < 6);
    end
    refresh_ack = 1'b0;
    scrub_ack   = 1'b0;
    n_checks++;
    if (nscrub != 6) $display("FAIL scrub_count: got %0d want 6 within bound", nscrub);
    else n_pass++;
    n_checks++;
    if (wraps != 1) $display("FAIL wrap_pulses: got %0d want 1", wraps);
    else n_pass++;
    // Reset while scrub_req is raised at a non-base address.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if (scrub_req !== 1'b0 || scrub_addr !== 32'h1000 || refresh_debt !== 3'd0 ||
        refresh_overrun !== 1'b0) begin
      $display("FAIL rst_mid_scrub: got req %b addr %h debt %0d ovr %b want 0 00001000 0 0",
               scrub_req, scrub_addr, refresh_debt, refresh_overrun);
    end else n_pass++;
  endtask

  task automatic test_priority();
    do_reset(1'b0, 1'b1);
    goto(17);
    refresh_ack = 1'b1;
    step(1);
    refresh_ack = 1'b0;
    host_busy   = 1'b1;
    goto(40);
    n_checks++;
    if (refresh_debt !== 3'd1 || refresh_req !== 1'b0 || scrub_req !== 1'b0) begin
      $display("FAIL prio_c40: got debt %0d rreq %b sreq %b want 1 0 0", refresh_debt,
               refresh_req, scrub_req);
    end else n_pass++;
    host_busy = 1'b0;
    step(1);
    n_checks++;
    if (refresh_req !== 1'b1 || scrub_req !== 1'b0) begin
      $display("FAIL prio_ref_first_c41: got rreq %b sreq %b want 1 0", refresh_req, scrub_req);
    end else n_pass++;
    refresh_ack = 1'b1;
    step(1);
    refresh_ack = 1'b0;
    n_checks++;
    if (refresh_req !== 1'b0 || scrub_req !== 1'b0 || refresh_debt !== 3'd0) begin
      $display("FAIL prio_gap_c42: got rreq %b sreq %b debt %0d want 0 0 0", refresh_req,
               scrub_req, refresh_debt);
    end else n_pass++;
    step(1);
    n_checks++;
    if (scrub_req !== 1'b1 || refresh_req !== 1'b0) begin
      $display("FAIL prio_scrub_c43: got sreq %b rreq %b want 1 0", scrub_req, refresh_req);
    end else n_pass++;
    goto(80);
    n_checks++;
    if (refresh_urgent !== 1'b1 || scrub_req !== 1'b1 || refresh_req !== 1'b0) begin
      $display("FAIL nopreempt_c80: got urg %b sreq %b rreq %b want 1 1 0", refresh_urgent,
               scrub_req, refresh_req);
    end else n_pass++;
    step(1);
    scrub_ack = 1'b1;
    step(1);
    scrub_ack = 1'b0;
    n_checks++;
    if (scrub_req !== 1'b0 || refresh_req !== 1'b0 || scrub_addr !== 32'h1040) begin
      $display("FAIL scrub_done_c82: got sreq %b rreq %b addr %h want 0 0 00001040", scrub_req,
               refresh_req, scrub_addr);
    end else n_pass++;
    step(1);
    n_checks++;
    if (refresh_req !== 1'b1 || refresh_debt !== 3'd3) begin
      $display("FAIL urgent_after_scrub_c83: got rreq %b debt %0d want 1 3", refresh_req,
               refresh_debt);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_refresh();
    test_postpone();
    test_collision();
    test_scrub_walk();
    test_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
